// File: rtl/dcache_rsp_stage_if.sv
// Bundles the dcache output-queue head, ROB resteer/completion and CDB request/broadcast signals.
// The slave modport is the drain stage; the master modport is whoever drives the queue, ROB and arbiter side.
interface dcache_rsp_stage_if #(
   parameter int DATA_SIZE    = 32,
   parameter int OOO_TAG_SIZE = 10,
   parameter int OOO_ROB_SIZE = 10
);
   logic                    q_valid;
   logic [31:0]             q_addr;
   logic [DATA_SIZE-1:0]    q_data;
   logic                    q_is_st;
   logic                    q_is_flush;
   logic [OOO_TAG_SIZE-1:0] q_tag;
   logic [OOO_ROB_SIZE-1:0] q_rob_line;
   logic                    q_pop;
   logic                    resteer;
   logic                    cdb_req;
   logic                    cdb_grant;
   logic                    cdb_valid;
   logic [OOO_TAG_SIZE-1:0] cdb_tag;
   logic [DATA_SIZE-1:0]    cdb_data;
   logic                    rob_cmpl_valid;
   logic [OOO_ROB_SIZE-1:0] rob_cmpl_line;
   logic                    rob_cmpl_is_flush;
   logic [31:0]             rob_cmpl_addr;

   modport slave (
      input  q_valid, q_addr, q_data, q_is_st, q_is_flush, q_tag, q_rob_line,
      input  resteer, cdb_grant,
      output q_pop, cdb_req, cdb_valid, cdb_tag, cdb_data,
      output rob_cmpl_valid, rob_cmpl_line, rob_cmpl_is_flush, rob_cmpl_addr
   );

   modport master (
      output q_valid, q_addr, q_data, q_is_st, q_is_flush, q_tag, q_rob_line,
      output resteer, cdb_grant,
      input  q_pop, cdb_req, cdb_valid, cdb_tag, cdb_data,
      input  rob_cmpl_valid, rob_cmpl_line, rob_cmpl_is_flush, rob_cmpl_addr
   );
endinterface

// File: rtl/dcache_rsp_stage.sv
// Drains one dcache op at a time: loads broadcast on the CDB once granted, stores/flushes complete to the ROB 1 cycle after pop.
// The head pops only when the holding register is empty or finishing; DCACHE_RSP_STATS_EN adds saturating op/stall counters.
module dcache_rsp_stage #(
   parameter int DATA_SIZE    = 32,
   parameter int OOO_TAG_SIZE = 10,
   parameter int OOO_ROB_SIZE = 10,
   parameter int STAT_WIDTH   = 16
) (
   input  logic clk,
   input  logic rst,
   dcache_rsp_stage_if.slave bus
`ifdef DCACHE_RSP_STATS_EN
   ,
   output logic [STAT_WIDTH-1:0] stat_ld_cnt,
   output logic [STAT_WIDTH-1:0] stat_st_cnt,
   output logic [STAT_WIDTH-1:0] stat_flush_cnt,
   output logic [STAT_WIDTH-1:0] stat_cdb_stall_cnt
`endif
);

   typedef enum logic [1:0] {EMPTY, CMPL, WAIT_CDB} state_t;

   state_t                  state;
   logic [31:0]             hold_addr;
   logic [DATA_SIZE-1:0]    hold_data;
   logic [OOO_TAG_SIZE-1:0] hold_tag;
   logic [OOO_ROB_SIZE-1:0] hold_line;
   logic                    hold_is_flush;

   logic live, ld_done, cmpl_done, finish, pop;

   // Reset and resteer both silence every strobe in the cycle they are seen.
   assign live      = ~rst & ~bus.resteer;
   assign ld_done   = live & (state == WAIT_CDB) & bus.cdb_grant;
   assign cmpl_done = live & (state == CMPL);
   assign finish    = ld_done | cmpl_done;
   assign pop       = live & bus.q_valid & ((state == EMPTY) | finish);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= EMPTY;
         hold_addr     <= '0;
         hold_data     <= '0;
         hold_tag      <= '0;
         hold_line     <= '0;
         hold_is_flush <= 1'b0;
      end else if (bus.resteer) begin
         state <= EMPTY;
      end else if (pop) begin
         state         <= (bus.q_is_st | bus.q_is_flush) ? CMPL : WAIT_CDB;
         hold_addr     <= bus.q_addr;
         hold_data     <= bus.q_data;
         hold_tag      <= bus.q_tag;
         hold_line     <= bus.q_rob_line;
         hold_is_flush <= bus.q_is_flush;
      end else if (finish) begin
         state <= EMPTY;
      end
   end

   assign bus.q_pop             = pop;
   assign bus.cdb_req           = live & (state == WAIT_CDB);
   assign bus.cdb_valid         = ld_done;
   assign bus.cdb_tag           = ld_done ? hold_tag  : '0;
   assign bus.cdb_data          = ld_done ? hold_data : '0;
   assign bus.rob_cmpl_valid    = finish;
   assign bus.rob_cmpl_line     = finish ? hold_line : '0;
   assign bus.rob_cmpl_is_flush = cmpl_done & hold_is_flush;
   assign bus.rob_cmpl_addr     = finish ? hold_addr : '0;

`ifdef DCACHE_RSP_STATS_EN
   function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_ld_cnt        <= '0;
         stat_st_cnt        <= '0;
         stat_flush_cnt     <= '0;
         stat_cdb_stall_cnt <= '0;
      end else begin
         if (ld_done)
            stat_ld_cnt <= sat_inc(stat_ld_cnt);
         if (cmpl_done & ~hold_is_flush)
            stat_st_cnt <= sat_inc(stat_st_cnt);
         if (cmpl_done & hold_is_flush)
            stat_flush_cnt <= sat_inc(stat_flush_cnt);
         if (live & (state == WAIT_CDB) & ~bus.cdb_grant)
            stat_cdb_stall_cnt <= sat_inc(stat_cdb_stall_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_dcache_rsp_stage.sv
// Directed table of per-cycle stimulus/expectation rows plus a long CDB-stall sequence for dcache_rsp_stage.
module tb_dcache_rsp_stage;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dcache_rsp_stage_if #(.DATA_SIZE(32), .OOO_TAG_SIZE(10), .OOO_ROB_SIZE(10)) bus ();

`ifdef DCACHE_RSP_STATS_EN
   logic [15:0] stat_ld_cnt, stat_st_cnt, stat_flush_cnt, stat_cdb_stall_cnt;
`endif

   dcache_rsp_stage #(.DATA_SIZE(32), .OOO_TAG_SIZE(10), .OOO_ROB_SIZE(10), .STAT_WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
`ifdef DCACHE_RSP_STATS_EN
      ,
      .stat_ld_cnt        (stat_ld_cnt),
      .stat_st_cnt        (stat_st_cnt),
      .stat_flush_cnt     (stat_flush_cnt),
      .stat_cdb_stall_cnt (stat_cdb_stall_cnt)
`endif
   );

   typedef struct {
      logic        rst, qv;
      logic [31:0] addr, data;
      logic        st, fl;
      logic [9:0]  tag, line;
      logic        rs, gr;
      logic        e_pop, e_req, e_cv;
      logic [9:0]  e_tag;
      logic [31:0] e_data;
      logic        e_rv;
      logic [9:0]  e_line;
      logic        e_fl;
      logic [31:0] e_addr;
   } vec_t;

   vec_t vq[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic add(input logic r, input logic qv, input logic [31:0] addr, input logic [31:0] data,
                      input logic st, input logic fl, input logic [9:0] tag, input logic [9:0] line,
                      input logic rs, input logic gr,
                      input logic e_pop, input logic e_req, input logic e_cv, input logic [9:0] e_tag,
                      input logic [31:0] e_data, input logic e_rv, input logic [9:0] e_line,
                      input logic e_fl, input logic [31:0] e_addr);
      vec_t v;
      v.rst = r; v.qv = qv; v.addr = addr; v.data = data; v.st = st; v.fl = fl;
      v.tag = tag; v.line = line; v.rs = rs; v.gr = gr;
      v.e_pop = e_pop; v.e_req = e_req; v.e_cv = e_cv; v.e_tag = e_tag; v.e_data = e_data;
      v.e_rv = e_rv; v.e_line = e_line; v.e_fl = e_fl; v.e_addr = e_addr;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (row %0d): got %h expected %h", nm, row, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic qv, input logic [31:0] addr, input logic [31:0] data,
                        input logic st, input logic fl, input logic [9:0] tag, input logic [9:0] line,
                        input logic rs, input logic gr);
      rst = r;
      bus.q_valid = qv; bus.q_addr = addr; bus.q_data = data;
      bus.q_is_st = st; bus.q_is_flush = fl; bus.q_tag = tag; bus.q_rob_line = line;
      bus.resteer = rs; bus.cdb_grant = gr;
   endtask

   task automatic check_all(input int row, input vec_t v);
      chk("q_pop",             row, 32'(bus.q_pop),             32'(v.e_pop));
      chk("cdb_req",           row, 32'(bus.cdb_req),           32'(v.e_req));
      chk("cdb_valid",         row, 32'(bus.cdb_valid),         32'(v.e_cv));
      chk("cdb_tag",           row, 32'(bus.cdb_tag),           32'(v.e_tag));
      chk("cdb_data",          row, bus.cdb_data,               v.e_data);
      chk("rob_cmpl_valid",    row, 32'(bus.rob_cmpl_valid),    32'(v.e_rv));
      chk("rob_cmpl_line",     row, 32'(bus.rob_cmpl_line),     32'(v.e_line));
      chk("rob_cmpl_is_flush", row, 32'(bus.rob_cmpl_is_flush), 32'(v.e_fl));
      chk("rob_cmpl_addr",     row, bus.rob_cmpl_addr,          v.e_addr);
   endtask

   initial begin
      vec_t v;
      // idle after reset
      add(0,0,0,0,0,0,0,0,0,0,                       0,0,0,0,0,0,0,0,0);
      // store, line 0x05
      add(0,1,'h40,'h1234,1,0,0,'h05,0,0,            1,0,0,0,0,0,0,0,0);
      add(0,0,0,0,0,0,0,0,0,0,                       0,0,0,0,0,1,'h05,0,'h40);
      add(0,0,0,0,0,0,0,0,0,0,                       0,0,0,0,0,0,0,0,0);
      // load with grant withheld three cycles, a store waiting behind it
      add(0,1,'h80,'hDEADBEEF,0,0,'h2A,'h11,0,0,     1,0,0,0,0,0,0,0,0);
      add(0,1,'h90,'h5A5A,1,0,0,'h22,0,0,            0,1,0,0,0,0,0,0,0);
      add(0,1,'h90,'h5A5A,1,0,0,'h22,0,0,            0,1,0,0,0,0,0,0,0);
      add(0,1,'h90,'h5A5A,1,0,0,'h22,0,0,            0,1,0,0,0,0,0,0,0);
      add(0,1,'h90,'h5A5A,1,0,0,'h22,0,1,            1,1,1,'h2A,'hDEADBEEF,1,'h11,0,'h80);
      add(0,0,0,0,0,0,0,0,0,1,                       0,0,0,0,0,1,'h22,0,'h90);
      add(0,0,0,0,0,0,0,0,0,0,                       0,0,0,0,0,0,0,0,0);
      // four streaming loads, grant tied high
      add(0,1,'h100,'h100,0,0,1,1,0,1,               1,0,0,0,0,0,0,0,0);
      add(0,1,'h200,'h200,0,0,2,2,0,1,               1,1,1,1,'h100,1,1,0,'h100);
      add(0,1,'h300,'h300,0,0,3,3,0,1,               1,1,1,2,'h200,1,2,0,'h200);
      add(0,1,'h400,'h400,0,0,4,4,0,1,               1,1,1,3,'h300,1,3,0,'h300);
      add(0,0,0,0,0,0,0,0,0,1,                       0,1,1,4,'h400,1,4,0,'h400);
      add(0,0,0,0,0,0,0,0,0,1,                       0,0,0,0,0,0,0,0,0);
      // resteer while a load waits for the CDB, second op queued
      add(0,1,'h200,'h5555,0,0,'h33,'h33,0,0,        1,0,0,0,0,0,0,0,0);
      add(0,1,'h240,'h6666,1,0,0,'h44,0,0,           0,1,0,0,0,0,0,0,0);
      add(0,1,'h240,'h6666,1,0,0,'h44,1,1,           0,0,0,0,0,0,0,0,0);
      add(0,0,0,0,0,0,0,0,0,1,                       0,0,0,0,0,0,0,0,0);
      // flush with is_st also set
      add(0,1,'h1000,'hAAAA,1,1,0,'h07,0,0,          1,0,0,0,0,0,0,0,0);
      add(0,0,0,0,0,0,0,0,0,1,                       0,0,0,0,0,1,'h07,1,'h1000);
      add(0,0,0,0,0,0,0,0,0,0,                       0,0,0,0,0,0,0,0,0);
      // rst with grant while a load waits
      add(0,1,'h300,'h77,0,0,'h55,'h55,0,0,          1,0,0,0,0,0,0,0,0);
      add(1,1,'h300,'h77,0,0,'h55,'h55,0,1,          0,0,0,0,0,0,0,0,0);
      add(0,0,0,0,0,0,0,0,0,1,                       0,0,0,0,0,0,0,0,0);

      drive(1,0,0,0,0,0,0,0,0,0);
      repeat (2) @(negedge clk);

      for (int i = 0; i < vq.size(); i++) begin
         v = vq[i];
         drive(v.rst, v.qv, v.addr, v.data, v.st, v.fl, v.tag, v.line, v.rs, v.gr);
         #2;
         check_all(i, v);
         @(negedge clk);
      end

`ifdef DCACHE_RSP_STATS_EN
      chk("stat_ld_cnt after rst",    200, 32'(stat_ld_cnt),        0);
      chk("stat_st_cnt after rst",    200, 32'(stat_st_cnt),        0);
      chk("stat_flush_cnt after rst", 200, 32'(stat_flush_cnt),     0);
      chk("stat_stall_cnt after rst", 200, 32'(stat_cdb_stall_cnt), 0);
`endif

      // long CDB stall with all-ones payload, store waiting behind it
      drive(0,1,'hFFFFFFFC,'hFFFFFFFF,0,0,'h3FF,'h3FF,0,0);
      #2;
      chk("stall pop", 100, 32'(bus.q_pop), 1);
      @(negedge clk);
      drive(0,1,'h500,'h9,1,0,0,'h1AB,0,0);
      for (int c = 0; c < 20; c++) begin
         #2;
         chk("stall req", 101 + c, 32'(bus.cdb_req),   1);
         chk("stall pop", 101 + c, 32'(bus.q_pop),     0);
         chk("stall cv",  101 + c, 32'(bus.cdb_valid), 0);
         @(negedge clk);
      end
      bus.cdb_grant = 1'b1;
      #2;
      chk("grant cv",   130, 32'(bus.cdb_valid),      1);
      chk("grant tag",  130, 32'(bus.cdb_tag),        'h3FF);
      chk("grant data", 130, bus.cdb_data,            'hFFFFFFFF);
      chk("grant line", 130, 32'(bus.rob_cmpl_line),  'h3FF);
      chk("grant addr", 130, bus.rob_cmpl_addr,       'hFFFFFFFC);
      chk("grant pop",  130, 32'(bus.q_pop),          1);
      @(negedge clk);
      drive(0,0,0,0,0,0,0,0,0,0);
      #2;
      chk("st rv",   131, 32'(bus.rob_cmpl_valid), 1);
      chk("st line", 131, 32'(bus.rob_cmpl_line),  'h1AB);
      chk("st addr", 131, bus.rob_cmpl_addr,       'h500);
      chk("st req",  131, 32'(bus.cdb_req),        0);
      @(negedge clk);
      #2;
      chk("idle rv", 132, 32'(bus.rob_cmpl_valid), 0);

`ifdef DCACHE_RSP_STATS_EN
      chk("stat_ld_cnt",    210, 32'(stat_ld_cnt),        1);
      chk("stat_st_cnt",    210, 32'(stat_st_cnt),        1);
      chk("stat_flush_cnt", 210, 32'(stat_flush_cnt),     0);
      chk("stat_stall_cnt", 210, 32'(stat_cdb_stall_cnt), 20);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
